// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit period and
// frame width. Used by both the receiver (uart_rx) and TX_MODULE.
package uart_pkg;

   // Default bit period: 100 MHz clock / 115200 baud
   localparam int DEF_BIT_CLK_PER = 868;
   localparam int DATA_BITS       = 8;

   // FSM state encodings (3-bit, plain constants for legacy tools)
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
   localparam logic [2:0] ST_PARITY    = 3'd5;

   // True while a frame is being received (start bit through stop bit)
   function automatic logic is_frame_state(input logic [2:0] state);
      return (state == ST_START) || (state == ST_DATA) ||
             (state == ST_PARITY) || (state == ST_STOP);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (UART RX) do not see a false edge at reset.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignments make r_sync take the old r_meta, so
         // the input really crosses two flops instead of collapsing into one.
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Samples each bit in its middle using a
// BIT_CLK_PER-clock bit period and emits one-cycle valid / frame-error pulses.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (parameter PARITY_ODD, output o_parity_err).
module uart_rx
   import uart_pkg::*;
#(
   parameter int BIT_CLK_PER = DEF_BIT_CLK_PER
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_rx_serial,
   output logic                 o_rx_valid,
   output logic [DATA_BITS-1:0] o_rx_byte,
   output logic                 o_rx_active,
`ifdef UART_RX_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic                 o_frame_err
);

   localparam int               CNT_W    = $clog2(BIT_CLK_PER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLK_PER - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLK_PER / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0]       ST_AFTER_DATA = ST_PARITY;
`else
   localparam logic [2:0]       ST_AFTER_DATA = ST_STOP;
`endif

   logic                 w_rx_s;
   logic                 w_cnt_last;
   logic [2:0]           r_state;
   logic [CNT_W-1:0]     r_clk_cnt;
   logic [2:0]           r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_byte;
   logic                 r_valid;
   logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit;
   logic                 r_par_err;
`endif

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_rx_serial),
      .o_sync    (w_rx_s)
   );

   assign w_cnt_last = (r_clk_cnt == CNT_LAST);

   // Frame FSM: start-bit qualification, mid-bit sampling and result pulses
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit   <= 1'b0;
         r_par_err   <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low every cycle; only the STOP branch
         // raises them, which guarantees single-cycle strobes.
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (!w_rx_s) begin
                  r_state   <= ST_START;
                  r_clk_cnt <= '0;
               end
            end
            ST_START: begin
               if (r_clk_cnt == CNT_HALF) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= '0;
                  // Still low at mid start bit: real frame, else a glitch
                  r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (w_cnt_last) begin
                  r_clk_cnt          <= '0;
                  r_shift[r_bit_idx] <= w_rx_s;
                  if (r_bit_idx == LAST_BIT) r_state   <= ST_AFTER_DATA;
                  else                       r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_cnt_last) begin
                  r_clk_cnt <= '0;
                  r_par_bit <= w_rx_s;
                  r_state   <= ST_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (w_cnt_last) begin
                  r_clk_cnt <= '0;
                  if (w_rx_s) begin
                     // Leave mid-stop-bit so a following start bit is not missed
                     r_byte  <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     r_par_err <= ((^r_shift) ^ r_par_bit) != PARITY_ODD;
`endif
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_HIGH;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_ONE;
               end
            end
            ST_WAIT_HIGH: begin
               // Break condition: wait for the line to recover before rearming
               if (w_rx_s) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_rx_valid  = r_valid;
   assign o_rx_byte   = r_byte;
   assign o_frame_err = r_frame_err;
   assign o_rx_active = is_frame_state(r_state);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_par_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line driver models the remote
// transmitter and pushes the expected outcome of each frame into a queue; an
// independent monitor pops and compares whenever the DUT pulses an output.
module tb_uart_rx;

   localparam int BCP = 868;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam bit TB_PAR_ODD = 1'b0;
   // Rising edges from the first edge that sees the start bit on the pin
   // through the edge that raises the result pulse
   localparam longint LATENCY = 2 + BCP / 2 + (9 + PAR_BITS) * BCP + 1;
   localparam int NUM_RAND = (PAR_BITS != 0) ? 0 : 2;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      bit         par_err;
      longint     start;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_serial;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_active;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   longint     cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_pushed = 0;
   int         n_pulses = 0;
   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.BIT_CLK_PER(BCP)) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_rx_serial  (rx_serial),
      .o_rx_valid   (rx_valid),
      .o_rx_byte    (rx_byte),
      .o_rx_active  (rx_active),
`ifdef UART_RX_PARITY_EN
      .o_parity_err (parity_err),
`endif
      .o_frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hold the line at level b for n clocks (caller is at a falling edge)
   task automatic hold(input logic b, input int n);
      rx_serial = b;
      repeat (n) @(negedge clk);
   endtask

   // Transmit one frame and record what the receiver must report for it
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bit);
      exp_t e;
      e.start   = cyc;
      e.is_err  = !stop;
      e.data    = stop ? d : last_good;
      e.par_err = stop && ((($countones(d) + int'(par_bit)) % 2) != int'(TB_PAR_ODD));
      if (stop) last_good = d;
      exp_q.push_back(e);
      n_pushed++;
      hold(1'b0, BCP);
      for (int i = 0; i < 8; i++) hold(d[i], BCP);
`ifdef UART_RX_PARITY_EN
      hold(par_bit, BCP);
`endif
      hold(stop, BCP);
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return logic'(($countones(d) % 2) != int'(TB_PAR_ODD));
   endfunction

   // Monitor: compare every DUT pulse against the oldest expectation
   always @(negedge clk) begin
      if (rx_valid || frame_err) begin
         n_pulses++;
         check("valid_ferr_exclusive", rx_valid & frame_err, 1'b0);
         check("pulse_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("frame_err_kind", frame_err, mon_e.is_err);
            check("rx_byte", rx_byte, mon_e.data);
            check("pulse_latency", cyc - mon_e.start, LATENCY);
`ifdef UART_RX_PARITY_EN
            check("parity_err", parity_err, mon_e.par_err);
`endif
         end
      end
   end

   initial begin
      #(150_000 * 10);
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         wait_cnt;
      logic [7:0] d;

      rst_n     = 1'b0;
      rx_serial = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_byte", rx_byte, last_good);
      check("reset_active", rx_active, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
      check("reset_parity_err", parity_err, 1'b0);
`endif
      rst_n = 1'b1;
      hold(1'b1, 5);

      // Single frame
      send_frame(8'h6E, 1'b1, good_par(8'h6E));
      hold(1'b1, 10);

      // Back-to-back frames, no idle gap
      send_frame(8'h6E, 1'b1, good_par(8'h6E));
      send_frame(8'h7F, 1'b1, good_par(8'h7F));
      hold(1'b1, 10);

      // Short low glitch must be rejected at mid start bit
      hold(1'b0, 200);
      check("glitch_active_high", rx_active, 1'b1);
      rx_serial = 1'b1;
      wait_cnt  = 0;
      while (rx_active && wait_cnt < BCP / 2) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("glitch_active_drop", rx_active, 1'b0);
      hold(1'b1, 20);
      send_frame(8'hA5, 1'b1, good_par(8'hA5));
      hold(1'b1, 10);

      // Stop bit low followed by a break of three bit times
      d = 8'($urandom);
      send_frame(d, 1'b0, good_par(d));
      hold(1'b0, BCP + BCP / 2);
      check("break_active_low", rx_active, 1'b0);
      check("break_byte_held", rx_byte, last_good);
      hold(1'b0, 3 * BCP - (BCP + BCP / 2));
      hold(1'b1, BCP);
      send_frame(8'h3C, 1'b1, good_par(8'h3C));
      hold(1'b1, 10);

      // Asynchronous reset in the middle of data bit 4
      d = 8'h5A;
      hold(1'b0, BCP);
      for (int i = 0; i < 4; i++) hold(d[i], BCP);
      hold(d[4], BCP / 2);
      rst_n     = 1'b0;
      last_good = 8'h00;
      #1;
      check("midreset_valid", rx_valid, 1'b0);
      check("midreset_byte", rx_byte, last_good);
      check("midreset_active", rx_active, 1'b0);
      check("midreset_frame_err", frame_err, 1'b0);
      @(negedge clk);
      hold(1'b1, 5);
      rst_n = 1'b1;
      hold(1'b1, 10);
      send_frame(8'hA5, 1'b1, good_par(8'hA5));

      // Random bytes with random idle gaps
      for (int i = 0; i < NUM_RAND; i++) begin
         hold(1'b1, $urandom_range(0, 20));
         d = 8'($urandom);
         send_frame(d, 1'b1, good_par(d));
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: 8'h07 has three ones, so the correct parity bit is 1
      hold(1'b1, 10);
      send_frame(8'h07, 1'b1, 1'b0);
      hold(1'b1, 10);
      send_frame(8'h07, 1'b1, 1'b1);
`endif

      hold(1'b1, 50);
      check("scoreboard_empty", exp_q.size(), 0);
      check("pulse_count", n_pulses, n_pushed);
      check("final_active", rx_active, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
